// File: rtl/gshare_btb_predictor_if.sv
// Fetch/execute/decode connection bundle for gshare_btb_predictor.
// master = pipeline side driving lookups, updates and stack ops; slave = predictor.
interface gshare_btb_predictor_if #(
  parameter int GHR_W = 10
);
  logic             ready;
  logic             pred_req;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispredict;
  logic             ras_push;
  logic [31:0]      ras_push_addr;
  logic             ras_pop;
  logic [31:0]      ras_top;
  logic             ras_valid;

  modport master (
    input  ready, pred_taken, pred_target, pred_ghr, ras_top, ras_valid,
    output pred_req, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
           upd_target, upd_mispredict, ras_push, ras_push_addr, ras_pop
  );

  modport slave (
    output ready, pred_taken, pred_target, pred_ghr, ras_top, ras_valid,
    input  pred_req, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
           upd_target, upd_mispredict, ras_push, ras_push_addr, ras_pop
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Gshare direction table + tagged direct-mapped BTB with speculative history and recovery.
// Define RAS_EN to add the circular return address stack driven from decode.
module gshare_btb_predictor #(
  parameter int GHR_W     = 10,
  parameter int CTR_W     = 2,
  parameter int BTB_IDX_W = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gshare_btb_predictor_if.slave bus
);
  localparam int PHT_DEPTH = 1 << GHR_W;
  localparam int BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int SWEEP_W   = (GHR_W > BTB_IDX_W) ? GHR_W : BTB_IDX_W;
  localparam int TAG_W     = 30 - BTB_IDX_W;

  localparam logic [CTR_W-1:0]   CTR_WNT    = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]   CTR_MAX    = '1;
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             r_state;
  logic [SWEEP_W-1:0] r_init_cnt;
  logic [GHR_W-1:0]   r_ghr;
  logic               r_ready;

  logic [CTR_W-1:0] r_pht       [PHT_DEPTH];
  logic             r_btb_valid [BTB_DEPTH];
  logic [TAG_W-1:0] r_btb_tag   [BTB_DEPTH];
  logic [31:0]      r_btb_tgt   [BTB_DEPTH];

  logic [GHR_W-1:0]     w_pht_idx;
  logic [BTB_IDX_W-1:0] w_btb_idx;
  logic                 w_hit;
  logic                 w_pred_taken;
  logic [GHR_W-1:0]     w_upd_pht_idx;
  logic [BTB_IDX_W-1:0] w_upd_btb_idx;
  logic [CTR_W-1:0]     w_ctr_cur;
  logic [CTR_W-1:0]     w_ctr_next;
  logic                 w_init_we;
  logic                 w_train;

  assign w_pht_idx     = bus.pred_pc[GHR_W+1:2] ^ r_ghr;
  assign w_btb_idx     = bus.pred_pc[BTB_IDX_W+1:2];
  assign w_hit         = (r_state == S_RUN) && r_btb_valid[w_btb_idx] &&
                         (r_btb_tag[w_btb_idx] == bus.pred_pc[31:BTB_IDX_W+2]);
  assign w_pred_taken  = w_hit && r_pht[w_pht_idx][CTR_W-1];

  assign w_upd_pht_idx = bus.upd_pc[GHR_W+1:2] ^ bus.upd_ghr;
  assign w_upd_btb_idx = bus.upd_pc[BTB_IDX_W+1:2];
  assign w_ctr_cur     = r_pht[w_upd_pht_idx];
  assign w_init_we     = rst_n && (r_state == S_INIT);
  assign w_train       = rst_n && (r_state == S_RUN) && bus.upd_valid;

  assign bus.ready       = r_ready;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_hit ? r_btb_tgt[w_btb_idx] : 32'h0;
  assign bus.pred_ghr    = r_ghr;

  // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (bus.upd_taken && (w_ctr_cur != CTR_MAX)) begin
      w_ctr_next = w_ctr_cur + 1'b1;
    end else if (!bus.upd_taken && (w_ctr_cur != '0)) begin
      w_ctr_next = w_ctr_cur - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_ghr      <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == SWEEP_LAST) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          // A resolved mispredict rebuilds history and overrides any speculative shift.
          if (bus.upd_valid && bus.upd_mispredict) begin
            r_ghr <= {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
          end else if (bus.pred_req && w_hit) begin
            r_ghr <= {r_ghr[GHR_W-2:0], w_pred_taken};
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // NOTE: table storage has no reset; the INIT sweep establishes every entry before RUN.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      if (int'(r_init_cnt) < PHT_DEPTH) r_pht[r_init_cnt[GHR_W-1:0]] <= CTR_WNT;
      if (int'(r_init_cnt) < BTB_DEPTH) r_btb_valid[r_init_cnt[BTB_IDX_W-1:0]] <= 1'b0;
    end else if (w_train) begin
      r_pht[w_upd_pht_idx] <= w_ctr_next;
      if (bus.upd_taken) begin
        r_btb_valid[w_upd_btb_idx] <= 1'b1;
        r_btb_tag[w_upd_btb_idx]   <= bus.upd_pc[31:BTB_IDX_W+2];
        r_btb_tgt[w_upd_btb_idx]   <= bus.upd_target;
      end
    end
  end

`ifdef RAS_EN
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_PTR_W:0] RAS_FULL = (RAS_PTR_W + 1)'(RAS_DEPTH);

  logic [31:0]          r_ras [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_ras_ptr;
  logic [RAS_PTR_W:0]   r_ras_cnt;
  logic                 w_ras_valid;

  assign w_ras_valid   = (r_ras_cnt != '0);
  assign bus.ras_valid = w_ras_valid;
  assign bus.ras_top   = w_ras_valid ? r_ras[r_ras_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (bus.ras_push && !bus.ras_pop) begin
      r_ras_ptr <= r_ras_ptr + 1'b1;
      if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (bus.ras_pop && !bus.ras_push && w_ras_valid) begin
      r_ras_ptr <= r_ras_ptr - 1'b1;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end

  // Push+pop together rewrites the current top; a lone push overwrites the oldest slot on wrap.
  always_ff @(posedge clk) begin
    if (rst_n && bus.ras_push) begin
      if (bus.ras_pop) r_ras[r_ras_ptr]        <= bus.ras_push_addr;
      else             r_ras[r_ras_ptr + 1'b1] <= bus.ras_push_addr;
    end
  end

  logic w_unused;
  assign w_unused = ^{bus.pred_pc[1:0], bus.upd_pc[1:0]};
`else
  assign bus.ras_valid = 1'b0;
  assign bus.ras_top   = 32'h0;

  logic w_unused;
  assign w_unused = ^{bus.pred_pc[1:0], bus.upd_pc[1:0], bus.ras_push, bus.ras_pop,
                      bus.ras_push_addr, (RAS_DEPTH != 0)};
`endif
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench for gshare_btb_predictor: expectations queued at drive time, checked before each edge.
module tb_gshare_btb_predictor;
  localparam int GHR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gshare_btb_predictor_if #(.GHR_W(GHR_W)) bus ();

  gshare_btb_predictor #(
    .GHR_W(GHR_W), .CTR_W(2), .BTB_IDX_W(6), .RAS_DEPTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef enum {K_READY, K_TAKEN, K_TARGET, K_GHR, K_RAS_TOP, K_RAS_VALID} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t             sb_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [GHR_W-1:0] m_ghr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.exp = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_READY:     return 32'(bus.ready);
      K_TAKEN:     return 32'(bus.pred_taken);
      K_TARGET:    return bus.pred_target;
      K_GHR:       return 32'(bus.pred_ghr);
      K_RAS_TOP:   return bus.ras_top;
      default:     return 32'(bus.ras_valid);
    endcase
  endfunction

  task automatic drain();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic idle();
    bus.pred_req = 1'b0;      bus.pred_pc = '0;
    bus.upd_valid = 1'b0;     bus.upd_pc = '0;      bus.upd_ghr = '0;
    bus.upd_taken = 1'b0;     bus.upd_target = '0;  bus.upd_mispredict = 1'b0;
    bus.ras_push = 1'b0;      bus.ras_push_addr = '0; bus.ras_pop = 1'b0;
  endtask

  // Inputs change at negedge; outputs compared 1 ns later, then one active edge passes.
  task automatic tick();
    #1;
    drain();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bus.pred_req = 1'b0;
    bus.pred_pc  = pc;
    expect_out({tag, "_taken"}, K_TAKEN, 32'(t));
    expect_out({tag, "_target"}, K_TARGET, tgt);
    expect_out({tag, "_ghr"}, K_GHR, 32'(m_ghr));
    tick();
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic hit);
    bus.pred_req = 1'b1;
    bus.pred_pc  = pc;
    expect_out({tag, "_taken"}, K_TAKEN, 32'(t));
    expect_out({tag, "_target"}, K_TARGET, tgt);
    expect_out({tag, "_ghr"}, K_GHR, 32'(m_ghr));
    tick();
    if (hit) m_ghr = {m_ghr[GHR_W-2:0], t};
    bus.pred_req = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [GHR_W-1:0] g, input logic t,
                       input logic [31:0] tgt, input logic mis);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_ghr = g;
    bus.upd_taken = t;    bus.upd_target = tgt; bus.upd_mispredict = mis;
    tick();
    if (mis) m_ghr = {g[GHR_W-2:0], t};
    bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
  endtask

  task automatic ras_op(input logic push, input logic [31:0] addr, input logic pop);
    bus.ras_push = push; bus.ras_push_addr = addr; bus.ras_pop = pop;
    tick();
    bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
  endtask

  task automatic ras_expect(input string tag, input logic v, input logic [31:0] top);
    expect_out({tag, "_valid"}, K_RAS_VALID, 32'(v));
    expect_out({tag, "_top"}, K_RAS_TOP, top);
  endtask

  // Hammers lookups and mispredicting updates during INIT; all must be ignored.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (n < 2000) begin
      #1;
      if (bus.ready === 1'b1) break;
      bus.pred_req = 1'b1;  bus.pred_pc = $urandom & 32'hFFFF_FFFC;
      bus.upd_valid = 1'b1; bus.upd_pc = 32'h60; bus.upd_ghr = '1;
      bus.upd_taken = 1'b1; bus.upd_target = 32'hDEAD0; bus.upd_mispredict = 1'b1;
      expect_out({tag, "_init_taken"}, K_TAKEN, 32'h0);
      expect_out({tag, "_init_ready"}, K_READY, 32'h0);
      tick();
      n++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd1024);
    idle();
    m_ghr = '0;
    expect_out({tag, "_ready"}, K_READY, 32'h1);
    expect_out({tag, "_ghr"}, K_GHR, 32'h0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    tick();
    expect_out("rst_ready", K_READY, 32'h0);
    expect_out("rst_taken", K_TAKEN, 32'h0);
    expect_out("rst_target", K_TARGET, 32'h0);
    expect_out("rst_ghr", K_GHR, 32'h0);
    ras_expect("rst_ras", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_ready("boot");

    // Direction training on one branch; lookup in the training cycle sees the old value.
    lookup("cold", 32'h60, 1'b0, 32'h0);
    bus.pred_pc = 32'h60;
    expect_out("collide_taken", K_TAKEN, 32'h0);
    expect_out("collide_target", K_TARGET, 32'h0);
    train(32'h60, '0, 1'b1, 32'h40, 1'b0);
    lookup("train1", 32'h60, 1'b1, 32'h40);
    train(32'h60, '0, 1'b1, 32'h40, 1'b0);
    lookup("train2", 32'h60, 1'b1, 32'h40);
    train(32'h60, '0, 1'b0, 32'h999, 1'b0);
    lookup("nt1", 32'h60, 1'b1, 32'h40);
    train(32'h60, '0, 1'b0, 32'h999, 1'b0);
    lookup("nt2", 32'h60, 1'b0, 32'h40);

    // Same BTB index, different tag: miss, then replacement on taken training.
    train(32'h60, '0, 1'b1, 32'h40, 1'b0);
    lookup("alias_miss", 32'h160, 1'b0, 32'h0);
    lookup("alias_orig", 32'h60, 1'b1, 32'h40);
    train(32'h160, '0, 1'b1, 32'h80, 1'b0);
    lookup("alias_evict", 32'h60, 1'b0, 32'h0);
    lookup("alias_new", 32'h160, 1'b1, 32'h80);

    // Speculative history: shift only on hit, and the shifted history rehashes the PHT.
    fetch("spec_hit", 32'h160, 1'b1, 32'h80, 1'b1);
    fetch("spec_miss", 32'h400, 1'b0, 32'h0, 1'b0);
    fetch("spec_hash", 32'h160, 1'b0, 32'h80, 1'b1);

    // Recovery wins over a same-cycle speculative shift.
    bus.pred_req = 1'b1;
    bus.pred_pc  = 32'h160;
    expect_out("prio_taken", K_TAKEN, 32'h0);
    expect_out("prio_ghr", K_GHR, 32'(m_ghr));
    train(32'h200, 10'h155, 1'b1, 32'h300, 1'b1);
    bus.pred_req = 1'b0;
    check("prio_model", 32'(m_ghr), 32'h2AB);
    lookup("recov_t", 32'h200, 1'b0, 32'h300);
    train(32'h204, 10'h3FF, 1'b0, 32'h0, 1'b1);
    lookup("recov_nt", 32'h204, 1'b0, 32'h0);
    train(32'h208, 10'h000, 1'b1, 32'h500, 1'b0);
    lookup("nomis", 32'h208, 1'b0, 32'h500);

    // Counter saturation at both ends.
    for (int i = 0; i < 5; i++) train(32'h1004, m_ghr, 1'b1, 32'h700, 1'b0);
    lookup("sat_hi", 32'h1004, 1'b1, 32'h700);
    train(32'h1004, m_ghr, 1'b0, 32'h0, 1'b0);
    lookup("sat_hi_dec", 32'h1004, 1'b1, 32'h700);
    train(32'h1004, m_ghr, 1'b0, 32'h0, 1'b0);
    lookup("sat_mid", 32'h1004, 1'b0, 32'h700);
    for (int i = 0; i < 4; i++) train(32'h1004, m_ghr, 1'b0, 32'h0, 1'b0);
    lookup("sat_lo", 32'h1004, 1'b0, 32'h700);
    train(32'h1004, m_ghr, 1'b1, 32'h700, 1'b0);
    lookup("sat_lo_inc", 32'h1004, 1'b0, 32'h700);
    train(32'h1004, m_ghr, 1'b1, 32'h700, 1'b0);
    lookup("sat_lo_inc2", 32'h1004, 1'b1, 32'h700);

`ifdef RAS_EN
    ras_op(1'b1, 32'h104, 1'b0);
    ras_op(1'b1, 32'h208, 1'b0);
    ras_expect("ras_two", 1'b1, 32'h208);
    ras_op(1'b0, 32'h0, 1'b1);
    ras_expect("ras_pop1", 1'b1, 32'h104);
    ras_op(1'b0, 32'h0, 1'b1);
    ras_expect("ras_pop2", 1'b0, 32'h0);
    ras_op(1'b0, 32'h0, 1'b1);
    ras_expect("ras_pop_empty", 1'b0, 32'h0);
    ras_op(1'b1, 32'h10, 1'b0);
    ras_expect("ras_one", 1'b1, 32'h10);
    ras_op(1'b1, 32'h20, 1'b1);
    ras_expect("ras_replace", 1'b1, 32'h20);
    ras_op(1'b0, 32'h0, 1'b1);
    ras_expect("ras_replace_cnt", 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) ras_op(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
    for (int j = 0; j < 8; j++) begin
      ras_expect($sformatf("ras_ovf%0d", j), 1'b1, 32'h1000 + 32'(4 * (8 - j)));
      ras_op(1'b0, 32'h0, 1'b1);
    end
    ras_expect("ras_ovf_empty", 1'b0, 32'h0);
    ras_op(1'b1, 32'hABC, 1'b0);
    ras_expect("ras_before_rst", 1'b1, 32'hABC);
`else
    ras_op(1'b1, 32'h104, 1'b0);
    ras_expect("ras_off_push", 1'b0, 32'h0);
    ras_op(1'b1, 32'h208, 1'b1);
    ras_expect("ras_off_mixed", 1'b0, 32'h0);
`endif

    // Mid-operation reset: back to INIT, tables re-swept, stack cleared.
    rst_n = 1'b0;
    bus.pred_pc = 32'h1004;
    tick();
    expect_out("mid_rst_ready", K_READY, 32'h0);
    expect_out("mid_rst_taken", K_TAKEN, 32'h0);
    expect_out("mid_rst_target", K_TARGET, 32'h0);
    expect_out("mid_rst_ghr", K_GHR, 32'h0);
    ras_expect("mid_rst_ras", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_ready("reboot");
    lookup("reinit", 32'h1004, 1'b0, 32'h0);
    lookup("reinit_alias", 32'h160, 1'b0, 32'h0);

    #1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
